// File: rtl/game_timer_ctrl.sv
// Round countdown controller: holds a 3-digit BCD time (tens.ones.tenths of seconds),
// sequences the external 100 ms tick timer and flags expiry.
module game_timer_ctrl #(
  parameter logic [3:0] DEFAULT_TENS = 4'd3,
  parameter logic [3:0] DEFAULT_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       tick_100ms,
  output logic       timer_en,
  output logic       timer_reset_n,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       time_up,
  output logic       expired,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSED  = 3'd3,
    S_EXPIRED = 3'd4
  } state_t;

  state_t     state, next_state;
  logic [3:0] next_tens, next_ones, next_tenths;
  logic [3:0] dec_tens, dec_ones, dec_tenths;
  logic [3:0] cap_tens, cap_ones;
  logic       dec_zero;

  assign dbg_state = state;
  assign cap_tens  = (load_tens > 4'd9) ? 4'd9 : load_tens;
  assign cap_ones  = (load_ones > 4'd9) ? 4'd9 : load_ones;

  // One-tenth BCD decrement with borrow; only used in RUN, where the value is nonzero.
  always_comb begin
    dec_tens   = sec_tens;
    dec_ones   = sec_ones;
    dec_tenths = tenths;
    if (tenths != 4'd0) begin
      dec_tenths = tenths - 4'd1;
    end else begin
      dec_tenths = 4'd9;
      if (sec_ones != 4'd0) begin
        dec_ones = sec_ones - 4'd1;
      end else begin
        dec_ones = 4'd9;
        if (sec_tens != 4'd0) dec_tens = sec_tens - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0) && (dec_tenths == 4'd0);

  always_comb begin
    next_state  = state;
    next_tens   = sec_tens;
    next_ones   = sec_ones;
    next_tenths = tenths;
    case (state)
      S_IDLE, S_EXPIRED: begin
        if (start) begin
          next_state  = S_ARM;
          next_tens   = cap_tens;
          next_ones   = cap_ones;
          next_tenths = 4'd0;
        end
      end
      S_ARM: begin
        if ((sec_tens != 4'd0) || (sec_ones != 4'd0) || (tenths != 4'd0))
          next_state = S_RUN;
        else
          next_state = S_EXPIRED;
      end
      S_RUN: begin
        // A tick coinciding with pause is still counted; reaching 0.0 expires regardless.
        if (tick_100ms) begin
          next_tens   = dec_tens;
          next_ones   = dec_ones;
          next_tenths = dec_tenths;
          if (dec_zero)   next_state = S_EXPIRED;
          else if (pause) next_state = S_PAUSED;
        end else if (pause) begin
          next_state = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (!pause) next_state = S_RUN;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort) begin
      next_state  = S_IDLE;
      next_tens   = sec_tens;
      next_ones   = sec_ones;
      next_tenths = tenths;
    end
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      sec_tens      <= DEFAULT_TENS;
      sec_ones      <= DEFAULT_ONES;
      tenths        <= 4'd0;
      timer_en      <= 1'b0;
      timer_reset_n <= 1'b0;
      running       <= 1'b0;
      time_up       <= 1'b0;
      expired       <= 1'b0;
    end else begin
      state         <= next_state;
      sec_tens      <= next_tens;
      sec_ones      <= next_ones;
      tenths        <= next_tenths;
      timer_en      <= (next_state == S_RUN);
      running       <= (next_state == S_RUN);
      timer_reset_n <= (next_state != S_ARM);
      expired       <= (next_state == S_EXPIRED);
      time_up       <= (next_state == S_EXPIRED) && (state != S_EXPIRED);
    end
  end

endmodule
